// File: rtl/tq_ram_pkg.sv
// Shared definitions for the TQ lane RAM: FSM states, lane slicing and parity sizing.
// Parity storage is enabled by defining TQ_RAM_PARITY_EN.
package tq_ram_pkg;

    typedef enum logic {
        TQ_RAM_INIT = 1'b0,
        TQ_RAM_RUN  = 1'b1
    } tq_ram_state_e;

    localparam int TQ_RAM_PAR_W = 1;

`ifdef TQ_RAM_PARITY_EN
    localparam bit TQ_RAM_PARITY = 1'b1;
`else
    localparam bit TQ_RAM_PARITY = 1'b0;
`endif

    function automatic int lane_lsb(input int lane, input int lane_width);
        return lane * lane_width;
    endfunction

endpackage

// File: rtl/tq_ram_1p_lane_array.sv
// Masked-write, synchronous-read storage array for the TQ lane RAM.
// With TQ_RAM_PARITY_EN each lane carries an even-parity bit checked on read.
module tq_ram_1p_lane_array
    import tq_ram_pkg::*;
#(
    parameter int LANE_WIDTH = 16,
    parameter int LANE_NUM   = 4,
    parameter int Addr_Width = 5
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           we,
    input  logic                           re,
    input  logic [LANE_NUM-1:0]            msk,
    input  logic [Addr_Width-1:0]          addr,
    input  logic [LANE_NUM*LANE_WIDTH-1:0] wdat,
    output logic [LANE_NUM*LANE_WIDTH-1:0] rdat
`ifdef TQ_RAM_PARITY_EN
    ,
    output logic [LANE_NUM-1:0]            par_err
`endif
);

    localparam int W     = LANE_NUM * LANE_WIDTH;
    localparam int DEPTH = 2 ** Addr_Width;
    localparam int MEM_W = W + (TQ_RAM_PARITY ? LANE_NUM * TQ_RAM_PAR_W : 0);

    logic [MEM_W-1:0] mem [DEPTH];

    // Parity bits sit above the data word, one per lane in lane order.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int k = 0; k < LANE_NUM; k++) begin
                if (msk[k]) begin
                    mem[addr][lane_lsb(k, LANE_WIDTH) +: LANE_WIDTH] <= wdat[lane_lsb(k, LANE_WIDTH) +: LANE_WIDTH];
`ifdef TQ_RAM_PARITY_EN
                    mem[addr][W + k] <= ^wdat[lane_lsb(k, LANE_WIDTH) +: LANE_WIDTH];
`endif
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rdat <= '0;
`ifdef TQ_RAM_PARITY_EN
            par_err <= '0;
`endif
        end else if (re) begin
            rdat <= mem[addr][W-1:0];
`ifdef TQ_RAM_PARITY_EN
            for (int k = 0; k < LANE_NUM; k++) begin
                par_err[k] <= (^mem[addr][lane_lsb(k, LANE_WIDTH) +: LANE_WIDTH]) ^ mem[addr][W + k];
            end
`endif
        end
    end

endmodule

// File: rtl/tq_ram_1p_lane.sv
// Single-port lane RAM controller: clear FSM, valid/ready request port, optional output stage.
// Optional per-lane parity checking is enabled by defining TQ_RAM_PARITY_EN.
module tq_ram_1p_lane
    import tq_ram_pkg::*;
#(
    parameter int LANE_WIDTH = 16,
    parameter int LANE_NUM   = 4,
    parameter int Addr_Width = 5,
    parameter int OUT_REG    = 0
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           clr_i,
    input  logic                           req_val_i,
    output logic                           req_rdy_o,
    input  logic                           req_wen_i,
    input  logic [LANE_NUM-1:0]            req_msk_i,
    input  logic [Addr_Width-1:0]          req_addr_i,
    input  logic [LANE_NUM*LANE_WIDTH-1:0] req_dat_i,
    output logic                           rd_val_o,
    output logic [LANE_NUM*LANE_WIDTH-1:0] rd_dat_o,
    output logic                           busy_o
`ifdef TQ_RAM_PARITY_EN
    ,
    output logic [LANE_NUM-1:0]            par_err_o
`endif
);

    localparam int W = LANE_NUM * LANE_WIDTH;

    tq_ram_state_e         state;
    logic [Addr_Width-1:0] clr_cnt;
    logic                  accept;
    logic                  arr_we;
    logic                  arr_re;
    logic [LANE_NUM-1:0]   arr_msk;
    logic [Addr_Width-1:0] arr_addr;
    logic [W-1:0]          arr_wdat;
    logic [W-1:0]          arr_rdat;
    logic                  rd_v1;
`ifdef TQ_RAM_PARITY_EN
    logic [LANE_NUM-1:0]   arr_err;
`endif

    // A clear request wins over everything and restarts the fill from address 0.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state   <= TQ_RAM_INIT;
            clr_cnt <= '0;
        end else if (clr_i) begin
            state   <= TQ_RAM_INIT;
            clr_cnt <= '0;
        end else if (state == TQ_RAM_INIT) begin
            clr_cnt <= clr_cnt + 1'b1;
            if (clr_cnt == '1) begin
                state <= TQ_RAM_RUN;
            end
        end
    end

    assign req_rdy_o = (state == TQ_RAM_RUN) && !clr_i;
    assign busy_o    = (state == TQ_RAM_INIT);
    assign accept    = req_val_i && req_rdy_o;

    always_comb begin
        arr_we   = 1'b0;
        arr_re   = 1'b0;
        arr_msk  = req_msk_i;
        arr_addr = req_addr_i;
        arr_wdat = req_dat_i;
        if (state == TQ_RAM_INIT) begin
            arr_we   = 1'b1;
            arr_msk  = '1;
            arr_addr = clr_cnt;
            arr_wdat = '0;
        end else begin
            arr_we = accept && req_wen_i;
            arr_re = accept && !req_wen_i;
        end
    end

    tq_ram_1p_lane_array #(
        .LANE_WIDTH (LANE_WIDTH),
        .LANE_NUM   (LANE_NUM),
        .Addr_Width (Addr_Width)
    ) u_array (
        .clk     (clk),
        .rstn    (rstn),
        .we      (arr_we),
        .re      (arr_re),
        .msk     (arr_msk),
        .addr    (arr_addr),
        .wdat    (arr_wdat),
        .rdat    (arr_rdat)
`ifdef TQ_RAM_PARITY_EN
        ,
        .par_err (arr_err)
`endif
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rd_v1 <= 1'b0;
        end else begin
            rd_v1 <= arr_re;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic         val_q;
            logic [W-1:0] dat_q;
`ifdef TQ_RAM_PARITY_EN
            logic [LANE_NUM-1:0] err_q;
`endif

            // Data only advances on a valid beat so the output holds between reads.
            always_ff @(posedge clk) begin
                if (!rstn) begin
                    val_q <= 1'b0;
                    dat_q <= '0;
`ifdef TQ_RAM_PARITY_EN
                    err_q <= '0;
`endif
                end else begin
                    val_q <= rd_v1;
                    if (rd_v1) begin
                        dat_q <= arr_rdat;
`ifdef TQ_RAM_PARITY_EN
                        err_q <= arr_err;
`endif
                    end
                end
            end

            assign rd_val_o = val_q;
            assign rd_dat_o = dat_q;
`ifdef TQ_RAM_PARITY_EN
            assign par_err_o = val_q ? err_q : '0;
`endif
        end else begin : g_no_reg
            assign rd_val_o = rd_v1;
            assign rd_dat_o = arr_rdat;
`ifdef TQ_RAM_PARITY_EN
            assign par_err_o = rd_v1 ? arr_err : '0;
`endif
        end
    endgenerate

endmodule

// File: tb/tb_tq_ram_1p_lane.sv
// Self-checking bench for tq_ram_1p_lane: one instance per read latency, shared stimulus,
// a queue-based reference model and directed literal checks. Parity checks under TQ_RAM_PARITY_EN.
module tb_tq_ram_1p_lane;

    localparam int DEPTH = 32;

    logic        clk = 1'b0;
    logic        rstn;
    logic        clr_i;
    logic        req_val_i;
    logic        req_wen_i;
    logic [3:0]  req_msk_i;
    logic [4:0]  req_addr_i;
    logic [63:0] req_dat_i;

    logic        rdy0, val0, busy0;
    logic [63:0] dat0;
    logic        rdy1, val1, busy1;
    logic [63:0] dat1;
`ifdef TQ_RAM_PARITY_EN
    logic [3:0]  par0, par1;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    tq_ram_1p_lane #(.LANE_WIDTH(16), .LANE_NUM(4), .Addr_Width(5), .OUT_REG(0)) dut0 (
        .clk(clk), .rstn(rstn), .clr_i(clr_i), .req_val_i(req_val_i), .req_rdy_o(rdy0),
        .req_wen_i(req_wen_i), .req_msk_i(req_msk_i), .req_addr_i(req_addr_i), .req_dat_i(req_dat_i),
        .rd_val_o(val0), .rd_dat_o(dat0), .busy_o(busy0)
`ifdef TQ_RAM_PARITY_EN
        , .par_err_o(par0)
`endif
    );

    tq_ram_1p_lane #(.LANE_WIDTH(16), .LANE_NUM(4), .Addr_Width(5), .OUT_REG(1)) dut1 (
        .clk(clk), .rstn(rstn), .clr_i(clr_i), .req_val_i(req_val_i), .req_rdy_o(rdy1),
        .req_wen_i(req_wen_i), .req_msk_i(req_msk_i), .req_addr_i(req_addr_i), .req_dat_i(req_dat_i),
        .rd_val_o(val1), .rd_dat_o(dat1), .busy_o(busy1)
`ifdef TQ_RAM_PARITY_EN
        , .par_err_o(par1)
`endif
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: memory contents, clear progress and pending read responses.
    typedef struct {
        int          due;
        logic [63:0] dat;
        logic [3:0]  err;
    } resp_t;

    logic [63:0] m_mem [DEPTH];
    logic [3:0]  m_err [DEPTH];
    resp_t       q0[$];
    resp_t       q1[$];
    resp_t       r;
    int          m_left = DEPTH;
    int          ncyc   = 0;
    bit          chk_en = 1'b0;
    logic [63:0] last0, last1;
    logic [3:0]  ee0, ee1;
    logic        ev0, ev1;

    always @(posedge clk) begin
        ncyc++;
        if (!rstn) begin
            chk_en = 1'b1;
            m_left = DEPTH;
            q0.delete();
            q1.delete();
            last0 = '0;
            last1 = '0;
            for (int a = 0; a < DEPTH; a++) begin
                m_mem[a] = '0;
                m_err[a] = '0;
            end
        end else begin
            if (m_left == 0 && !clr_i && req_val_i) begin
                if (req_wen_i) begin
                    for (int k = 0; k < 4; k++) begin
                        if (req_msk_i[k]) begin
                            m_mem[req_addr_i][k*16 +: 16] = req_dat_i[k*16 +: 16];
                            m_err[req_addr_i][k] = 1'b0;
                        end
                    end
                end else begin
                    r.dat = m_mem[req_addr_i];
                    r.err = m_err[req_addr_i];
                    r.due = ncyc;
                    q0.push_back(r);
                    r.due = ncyc + 1;
                    q1.push_back(r);
                end
            end
            if (clr_i) begin
                m_left = DEPTH;
                for (int a = 0; a < DEPTH; a++) begin
                    m_mem[a] = '0;
                    m_err[a] = '0;
                end
            end else if (m_left > 0) begin
                m_left--;
            end
        end
        #1;
        if (chk_en) begin
            ev0 = 1'b0;
            ee0 = '0;
            if (q0.size() > 0 && q0[0].due == ncyc) begin
                ev0 = 1'b1;
                last0 = q0[0].dat;
                ee0 = q0[0].err;
                void'(q0.pop_front());
            end
            ev1 = 1'b0;
            ee1 = '0;
            if (q1.size() > 0 && q1[0].due == ncyc) begin
                ev1 = 1'b1;
                last1 = q1[0].dat;
                ee1 = q1[0].err;
                void'(q1.pop_front());
            end
            checkOutput("busy0", 64'(busy0), 64'(m_left > 0));
            checkOutput("busy1", 64'(busy1), 64'(m_left > 0));
            checkOutput("rdy0", 64'(rdy0), 64'(m_left == 0 && !clr_i));
            checkOutput("rdy1", 64'(rdy1), 64'(m_left == 0 && !clr_i));
            checkOutput("rd_val0", 64'(val0), 64'(ev0));
            checkOutput("rd_val1", 64'(val1), 64'(ev1));
            checkOutput("rd_dat0", dat0, last0);
            checkOutput("rd_dat1", dat1, last1);
`ifdef TQ_RAM_PARITY_EN
            checkOutput("par_err0", 64'(par0), 64'(ee0));
            checkOutput("par_err1", 64'(par1), 64'(ee1));
`endif
        end
    end

    task automatic applyStimulus(input logic val, input logic wen, input logic [3:0] msk,
                                 input logic [4:0] addr, input logic [63:0] dat, input logic clr);
        @(negedge clk);
        req_val_i  = val;
        req_wen_i  = wen;
        req_msk_i  = msk;
        req_addr_i = addr;
        req_dat_i  = dat;
        clr_i      = clr;
    endtask

    task automatic applyIdle();
        applyStimulus(1'b0, 1'b0, 4'h0, 5'd0, 64'h0, 1'b0);
    endtask

    task automatic countBusy(output int n);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            if (!busy0) break;
            n++;
            @(negedge clk);
        end
    endtask

    task automatic readAndCheck(input logic [4:0] addr, input logic [63:0] exp);
        applyIdle();
        applyStimulus(1'b1, 1'b0, 4'h0, addr, 64'h0, 1'b0);
        applyIdle();
        checkOutput("lit_val_lat1", 64'(val0), 64'd1);
        checkOutput("lit_dat_lat1", dat0, exp);
        checkOutput("lit_val_lat2_early", 64'(val1), 64'd0);
        @(negedge clk);
        checkOutput("lit_val_lat2", 64'(val1), 64'd1);
        checkOutput("lit_dat_lat2", dat1, exp);
    endtask

    int nb;
    int first;
    int pulses;

    initial begin
        rstn = 1'b0; clr_i = 1'b0; req_val_i = 1'b0; req_wen_i = 1'b0;
        req_msk_i = '0; req_addr_i = '0; req_dat_i = '0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;

        // Power-up clear then all-zero contents
        countBusy(nb);
        checkOutput("init_busy_cycles", 64'(nb), 64'd32);
        checkOutput("rdy_after_init", 64'(rdy0), 64'd1);
        for (int a = 0; a < DEPTH; a++) applyStimulus(1'b1, 1'b0, 4'h0, 5'(a), 64'h0, 1'b0);
        readAndCheck(5'd31, 64'h0);

        // Masked writes and mask-zero no-op
        applyStimulus(1'b1, 1'b1, 4'hF, 5'd5, 64'hDDDD_CCCC_BBBB_AAAA, 1'b0);
        applyStimulus(1'b1, 1'b1, 4'b0101, 5'd5, 64'h1111_2222_3333_4444, 1'b0);
        applyStimulus(1'b1, 1'b1, 4'hF, 5'd3, 64'h0123_4567_89AB_CDEF, 1'b0);
        applyStimulus(1'b1, 1'b1, 4'h0, 5'd3, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        readAndCheck(5'd5, 64'hDDDD_2222_BBBB_4444);
        readAndCheck(5'd3, 64'h0123_4567_89AB_CDEF);

        // Write then read of the same address on consecutive cycles
        applyStimulus(1'b1, 1'b1, 4'hF, 5'd7, 64'hCAFE_F00D_1234_5678, 1'b0);
        applyStimulus(1'b1, 1'b0, 4'h0, 5'd7, 64'h0, 1'b0);
        applyIdle();
        checkOutput("wr_rd_val", 64'(val0), 64'd1);
        checkOutput("wr_rd_dat", dat0, 64'hCAFE_F00D_1234_5678);

        // Eight back-to-back reads, latency-2 instance timing
        for (int a = 0; a < 8; a++) applyStimulus(1'b1, 1'b1, 4'hF, 5'(a), 64'h0101_0101_0101_0101 * 64'(a + 1), 1'b0);
        applyIdle();
        applyIdle();
        first = -1;
        pulses = 0;
        applyStimulus(1'b1, 1'b0, 4'h0, 5'd0, 64'h0, 1'b0);
        for (int k = 1; k <= 12; k++) begin
            if (k < 8) applyStimulus(1'b1, 1'b0, 4'h0, 5'(k), 64'h0, 1'b0);
            else applyIdle();
            if (val1) begin
                pulses++;
                if (first < 0) first = k;
            end
        end
        checkOutput("stream_first_lat2", 64'(first), 64'd2);
        checkOutput("stream_pulses", 64'(pulses), 64'd8);

        // Clear in RUN with a read in flight and a request pending
        applyStimulus(1'b1, 1'b1, 4'hF, 5'd3, 64'h0123_4567_89AB_CDEF, 1'b0);
        applyIdle();
        applyStimulus(1'b1, 1'b0, 4'h0, 5'd3, 64'h0, 1'b0);
        applyStimulus(1'b1, 1'b1, 4'hF, 5'd3, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        #1;
        checkOutput("clr_rdy0", 64'(rdy0), 64'd0);
        checkOutput("clr_rdy1", 64'(rdy1), 64'd0);
        checkOutput("clr_inflight_val0", 64'(val0), 64'd1);
        checkOutput("clr_inflight_dat0", dat0, 64'h0123_4567_89AB_CDEF);
        applyIdle();
        checkOutput("clr_inflight_val1", 64'(val1), 64'd1);
        checkOutput("clr_inflight_dat1", dat1, 64'h0123_4567_89AB_CDEF);
        countBusy(nb);
        checkOutput("clr_busy_cycles", 64'(nb), 64'd32);
        for (int a = 0; a < DEPTH; a++) applyStimulus(1'b1, 1'b0, 4'h0, 5'(a), 64'h0, 1'b0);
        readAndCheck(5'd3, 64'h0);

        // Reset one cycle while the clear counter is at 10
        applyStimulus(1'b0, 1'b0, 4'h0, 5'd0, 64'h0, 1'b1);
        applyIdle();
        repeat (10) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        countBusy(nb);
        checkOutput("rst_mid_clear_busy_cycles", 64'(nb), 64'd32);
        readAndCheck(5'd20, 64'h0);

`ifdef TQ_RAM_PARITY_EN
        // Flip one data bit of lane 2 at address 9 behind the parity bit's back
        @(negedge clk);
        dut0.u_array.mem[9][32] = ~dut0.u_array.mem[9][32];
        dut1.u_array.mem[9][32] = ~dut1.u_array.mem[9][32];
        m_mem[9][32] = ~m_mem[9][32];
        m_err[9][2] = 1'b1;
        applyIdle();
        applyStimulus(1'b1, 1'b0, 4'h0, 5'd9, 64'h0, 1'b0);
        applyIdle();
        checkOutput("par_dat0", dat0, 64'h0000_0001_0000_0000);
        checkOutput("par_lit0", 64'(par0), 64'h4);
        @(negedge clk);
        checkOutput("par_lit1", 64'(par1), 64'h4);
        applyStimulus(1'b1, 1'b0, 4'h0, 5'd10, 64'h0, 1'b0);
        applyIdle();
        checkOutput("par_clean0", 64'(par0), 64'h0);
        checkOutput("par_clean_val0", 64'(val0), 64'd1);
`endif

        repeat (4) applyIdle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_fail++;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
